// File: rtl/path_stack_if.sv
// Solver/replay handshake bundle for path_stack.
// The ovf line exists only when PATH_STACK_OVF_EN is defined.
interface path_stack_if #(
  parameter int CW = 9
);
  logic          push;
  logic          pop;
  logic [1:0]    dirIn;
  logic          run;
  logic          moveReady;
  logic          empStck;
  logic          full;
  logic [CW-1:0] count;
  logic          moveValid;
  logic [1:0]    dirOut;
  logic          replayDone;
  logic          busy;
`ifdef PATH_STACK_OVF_EN
  logic          ovf;

  modport master (
    output push, pop, dirIn, run, moveReady,
    input  empStck, full, count, moveValid, dirOut, replayDone, busy, ovf
  );
  modport slave (
    input  push, pop, dirIn, run, moveReady,
    output empStck, full, count, moveValid, dirOut, replayDone, busy, ovf
  );
`else
  modport master (
    output push, pop, dirIn, run, moveReady,
    input  empStck, full, count, moveValid, dirOut, replayDone, busy
  );
  modport slave (
    input  push, pop, dirIn, run, moveReady,
    output empStck, full, count, moveValid, dirOut, replayDone, busy
  );
`endif
endinterface

// File: rtl/path_stack.sv
// Direction stack for a maze solver with bottom-to-top path replay.
// Optional sticky overflow flag: define PATH_STACK_OVF_EN.
//
// state  | meaning
// IDLE   | accepts push/pop/run from the solver
// REPLAY | presents mem[rdPtr] on dirOut until the top entry is taken
// FIN    | one-cycle replayDone pulse, then back to IDLE
module path_stack #(
  parameter int DEPTH = 256,
  parameter int CW    = 9
) (
  input logic         clk,
  input logic         rst,
  path_stack_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, REPLAY, FIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]    mem_q [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic          is_empty, is_full, last_move, hs;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CW'(DEPTH));
  assign last_move = (rd_ptr_q == count_q - CW'(1));
  assign hs        = (state_q == REPLAY) && bus.moveReady;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    we       = 1'b0;
    waddr    = count_q[AW-1:0];
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          rd_ptr_d = '0;
          state_d  = is_empty ? FIN : REPLAY;
        end else if (bus.push && bus.pop && !is_empty) begin
          // simultaneous push+pop overwrites the top entry in place
          we    = 1'b1;
          waddr = AW'(count_q - CW'(1));
        end else if (bus.push) begin
          if (!is_full) begin
            we      = 1'b1;
            count_d = count_q + CW'(1);
          end
        end else if (bus.pop) begin
          if (!is_empty) count_d = count_q - CW'(1);
        end
      end
      REPLAY: begin
        if (hs) begin
          if (last_move) state_d  = FIN;
          else           rd_ptr_d = rd_ptr_q + CW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // storage is not reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= bus.dirIn;
  end

  assign bus.moveValid  = (state_q == REPLAY);
  assign bus.dirOut     = bus.moveValid ? mem_q[rd_ptr_q[AW-1:0]] : 2'b00;
  assign bus.replayDone = (state_q == FIN);
  assign bus.busy       = (state_q != IDLE);
  assign bus.empStck    = is_empty;
  assign bus.full       = is_full;
  assign bus.count      = count_q;

`ifdef PATH_STACK_OVF_EN
  logic ovf_q, ovf_set, ovf_clr;

  assign ovf_clr = (state_q == IDLE) && bus.run;
  assign ovf_set = (state_q == IDLE) && !bus.run &&
                   ((bus.push && !bus.pop && is_full) ||
                    (bus.pop && !bus.push && is_empty));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovf_q <= 1'b0;
    else if (ovf_clr) ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_path_stack.sv
// Directed bench for path_stack: push/pop/replay, stalls, full/empty edges, reset abort.
module tb_path_stack;
  localparam int DEPTH = 256;
  localparam int CW    = 9;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  path_stack_if #(.CW(CW)) bus ();

  path_stack #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic psh, input logic pp, input logic [1:0] d);
    bus.push  = psh;
    bus.pop   = pp;
    bus.dirIn = d;
    tick();
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
  endtask

  task automatic start_run();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  logic [1:0] seq4 [4];
  logic [1:0] seq3 [3];

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.dirIn     = 2'd0;
    bus.run       = 1'b0;
    bus.moveReady = 1'b0;
    seq4[0] = 2'd1; seq4[1] = 2'd2; seq4[2] = 2'd3; seq4[3] = 2'd0;
    seq3[0] = 2'd3; seq3[1] = 2'd1; seq3[2] = 2'd2;

    tick();
    tick();
    check("rst_empStck", bus.empStck, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_moveValid", bus.moveValid, 0);
    check("rst_replayDone", bus.replayDone, 0);
    check("rst_dirOut", bus.dirOut, 0);
    rst = 1'b1;
    tick();

    // basic push of 1,2,3,0 then replay at full speed
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, seq4[i]);
    check("b_count", bus.count, 4);
    check("b_empStck", bus.empStck, 0);
    bus.moveReady = 1'b1;
    start_run();
    for (int i = 0; i < 4; i++) begin
      check("b_moveValid", bus.moveValid, 1);
      check("b_dirOut", bus.dirOut, seq4[i]);
      check("b_noDone", bus.replayDone, 0);
      tick();
    end
    check("b_done", bus.replayDone, 1);
    check("b_done_mv", bus.moveValid, 0);
    check("b_done_dir", bus.dirOut, 0);
    tick();
    check("b_done_once", bus.replayDone, 0);
    check("b_busy_fall", bus.busy, 0);
    check("b_count_kept", bus.count, 4);
    for (int i = 0; i < 4; i++) do_op(1'b0, 1'b1, 2'd0);
    check("b_cleared", bus.empStck, 1);

    // push 2, push 3, pop, push+pop(1) -> single entry 1
    do_op(1'b1, 1'b0, 2'd2);
    do_op(1'b1, 1'b0, 2'd3);
    do_op(1'b0, 1'b1, 2'd0);
    do_op(1'b1, 1'b1, 2'd1);
    check("r_count", bus.count, 1);
    start_run();
    check("r_mv", bus.moveValid, 1);
    check("r_dir", bus.dirOut, 1);
    tick();
    check("r_done", bus.replayDone, 1);
    tick();
    do_op(1'b0, 1'b1, 2'd0);
    check("r_cleared", bus.count, 0);

    // pop on empty, push+pop on empty, run on empty
    do_op(1'b0, 1'b1, 2'd0);
    check("e_pop_count", bus.count, 0);
`ifdef PATH_STACK_OVF_EN
    check("e_ovf_set", bus.ovf, 1);
`endif
    start_run();
    check("e_mv", bus.moveValid, 0);
    check("e_done", bus.replayDone, 1);
    check("e_busy", bus.busy, 1);
`ifdef PATH_STACK_OVF_EN
    check("e_ovf_clr", bus.ovf, 0);
`endif
    tick();
    check("e_done_once", bus.replayDone, 0);
    check("e_idle", bus.busy, 0);
    do_op(1'b1, 1'b1, 2'd2);
    check("e_pushpop_count", bus.count, 1);
    start_run();
    check("e_pushpop_dir", bus.dirOut, 2);
    tick();
    tick();
    do_op(1'b0, 1'b1, 2'd0);

    // replay of 3,1,2 with a 3-cycle stall on the second move; push during replay ignored
    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, seq3[i]);
    bus.moveReady = 1'b1;
    start_run();
    check("s_dir0", bus.dirOut, 3);
    tick();
    check("s_dir1", bus.dirOut, 1);
    bus.moveReady = 1'b0;
    bus.push      = 1'b1;
    bus.dirIn     = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s_stall_mv", bus.moveValid, 1);
      check("s_stall_dir", bus.dirOut, 1);
    end
    bus.push = 1'b0;
    check("s_push_ignored", bus.count, 3);
    bus.moveReady = 1'b1;
    tick();
    check("s_dir2", bus.dirOut, 2);
    tick();
    check("s_done", bus.replayDone, 1);
    tick();
    check("s_idle", bus.busy, 0);

    // reset in the middle of a replay (rdPtr == 1)
    start_run();
    check("a_dir0", bus.dirOut, 3);
    tick();
    check("a_dir1", bus.dirOut, 1);
    bus.moveReady = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("a_busy", bus.busy, 0);
    check("a_mv", bus.moveValid, 0);
    check("a_dir", bus.dirOut, 0);
    check("a_count", bus.count, 0);
    check("a_empStck", bus.empStck, 1);
    check("a_done", bus.replayDone, 0);
    tick();
    check("a_done_held", bus.replayDone, 0);
    rst = 1'b1;
    tick();
    check("a_done_after", bus.replayDone, 0);
    check("a_idle", bus.busy, 0);

    // fill to DEPTH, overflow push, top replace when full, full-depth replay
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 2'(i % 4));
    check("f_full", bus.full, 1);
    check("f_count", bus.count, DEPTH);
    do_op(1'b1, 1'b0, 2'd0);
    check("f_ovf_push_count", bus.count, DEPTH);
`ifdef PATH_STACK_OVF_EN
    check("f_ovf", bus.ovf, 1);
`endif
    do_op(1'b1, 1'b1, 2'd0);
    check("f_replace_count", bus.count, DEPTH);
    bus.moveReady = 1'b1;
    start_run();
`ifdef PATH_STACK_OVF_EN
    check("f_ovf_clr", bus.ovf, 0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("f_dir_top", bus.dirOut, 0);
      else                check("f_dir", bus.dirOut, 32'(i % 4));
      tick();
    end
    check("f_done", bus.replayDone, 1);
    tick();
    check("f_idle", bus.busy, 0);
    check("f_count_kept", bus.count, DEPTH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
